switch_allocator: RTL and testbench
===================================

# switch_allocator

- Separable input-first, round-robin switch allocator.
- Sits directly downstream of the router's input block and drives the crossbar.
- Each cycle it takes every input port's per-VC switch requests, output ports and downstream VCs, and filters them against downstream on/off flow control.
- It grants at most one VC per input port and at most one input per output port, then returns the grants to the input ports and the matching select to the crossbar.

## Interface
Parameters:
- PORT_NUM, 5, number of router ports (inputs = outputs).
- VC_NUM, 2, virtual channels per port.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- switch_request_i  in  [VC_NUM-1:0] x PORT_NUM  per input port, per VC: VC holds a flit ready to traverse the switch.
- out_port_i  in  [$clog2(PORT_NUM)-1:0] x VC_NUM x PORT_NUM  requested output port of each input VC.
- downstream_vc_i  in  [$clog2(VC_NUM)-1:0] x VC_NUM x PORT_NUM  downstream VC allocated to each input VC.
- on_off_i  in  [VC_NUM-1:0] x PORT_NUM  per output port, per downstream VC: 1 = downstream buffer accepts flits.
- valid_sel_o  out  [PORT_NUM-1:0]  input port p is granted this cycle.
- vc_sel_o  out  [$clog2(VC_NUM)-1:0] x PORT_NUM  granted VC index at input p; 0 when valid_sel_o[p]=0.
- xb_valid_o  out  [PORT_NUM-1:0]  output port o is driven this cycle.
- xb_sel_o  out  [$clog2(PORT_NUM)-1:0] x PORT_NUM  input port routed to output o; 0 when xb_valid_o[o]=0.
- error_o  out  [PORT_NUM-1:0]  input p has a requesting VC whose out_port_i >= PORT_NUM.

## Operation
**Eligibility.** VC v of input p is eligible when all three hold:
- switch_request_i[p][v] = 1;
- out_port_i[p][v] < PORT_NUM;
- on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]] = 1.

A requesting VC with an illegal out_port is never eligible and sets error_o[p].

**Stage 1 (input arbitration).**
- Per input p, a round-robin arbiter over the eligible VCs picks one winner.
- The search starts at in_ptr[p] and goes in ascending index order, wrapping modulo VC_NUM.

**Stage 2 (output arbitration).**
- Per output o, a round-robin arbiter runs over the inputs whose stage-1 winner targets o.
- The search starts at out_ptr[o], ascending, wrapping modulo PORT_NUM.

**Grant outputs.** When output o grants input p:
- xb_valid_o[o] = 1 and xb_sel_o[o] = p;
- valid_sel_o[p] = 1 and vc_sel_o[p] = the stage-1 winner.

**Pointer update (iSLIP rule).** Pointers move only on a final grant:
- in_ptr[p] <= (winner + 1) mod VC_NUM.
- out_ptr[o] <= (p + 1) mod PORT_NUM.
- An input that loses stage 2 keeps its in_ptr.
- An output with no grant keeps its out_ptr.

**Invariants (always hold):**
- Each output is granted to at most one input; each input is granted at most one VC.
- The valid_sel_o population equals the xb_valid_o population.

## Timing
- All grant outputs are combinational from the current-cycle inputs plus the pointer registers: zero-cycle latency.
- The input port samples the grant at the same rising edge that updates the pointers.
- Pointers are the only state; they update at the rising edge when rst=0.

Reset:
- While rst=1, all outputs are forced to 0 and nothing is granted.
- At the first edge with rst=1, every pointer loads 0.
- Reset asserted mid-operation discards pending arbitration state; the first cycle after deassertion arbitrates from pointer 0.

Boundary conditions:
- on_off_i drops to 0 in a cycle: the affected VCs become ineligible that same cycle.
- Simultaneous requests from all inputs to one output: exactly one grant per cycle, and all requesters are served within PORT_NUM cycles.
- Requests with no eligible VC at an input have no effect on that input's in_ptr.

## Configuration
- SWITCH_ALLOCATOR_PERF_CNT_EN defined: adds one 16-bit saturating grant counter per output port.
  - The counter increments on each cycle with xb_valid_o[o]=1 and sticks at 16'hFFFF.
  - It clears on rst.
  - It is exposed as output grant_cnt_o [15:0] x PORT_NUM.
- Not defined: the counters and the grant_cnt_o port are absent; grant behaviour is identical.

## Test plan
All scenarios use PORT_NUM=5, VC_NUM=2.
- **Reset:** hold rst=1 for 2 cycles with all requests high -> every output is 0; after release, input 0 VC0 to output 2 with on_off high -> valid_sel_o[0]=1, vc_sel_o[0]=0, xb_sel_o[2]=0.
- **Output contention:** inputs 0,1,3 each request output 4 via VC0, held 6 cycles -> grants go to 0,1,3,0,1,3; exactly one xb_valid_o[4] per cycle.
- **VC rotation:** input 2 requests output 1 on both VCs, held 4 cycles -> vc_sel_o[2] sequence 0,1,0,1.
- **Flow control:** on_off_i[3][1]=0, input 0 VC1 targets output 3 / downstream VC1 -> no grant; raise on_off the next cycle -> grant that same cycle.
- **Illegal port:** input 4 VC0 requests with out_port_i=6 -> error_o[4]=1, valid_sel_o[4]=0, no xb_valid_o asserted.
- **Full permutation:** input p requests output (p+1) mod 5 -> all five valid_sel_o and all five xb_valid_o high in one cycle; with SWITCH_ALLOCATOR_PERF_CNT_EN, after 3 cycles every grant_cnt_o reads 3.

Source files
------------

// File: rtl/switch_allocator_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : switch_allocator_if                                          |
// | Desc    : Request/flow-control/grant bundle between the input block,   |
// |           the switch allocator and the crossbar.                       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface switch_allocator_if #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
);
    localparam int c_PORT_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int c_VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_NUM-1:0][VC_NUM-1:0]               switch_request_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][c_PORT_W-1:0] out_port_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][c_VC_W-1:0]   downstream_vc_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]               on_off_i;
    logic [PORT_NUM-1:0]                           valid_sel_o;
    logic [PORT_NUM-1:0][c_VC_W-1:0]               vc_sel_o;
    logic [PORT_NUM-1:0]                           xb_valid_o;
    logic [PORT_NUM-1:0][c_PORT_W-1:0]             xb_sel_o;
    logic [PORT_NUM-1:0]                           error_o;

    modport master (
        output switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        input  valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o, error_o
    );

    modport slave (
        input  switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        output valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : switch_allocator                                             |
// | Desc    : Separable input-first round-robin switch allocator with      |
// |           iSLIP pointer update. Optional macro                         |
// |           SWITCH_ALLOCATOR_PERF_CNT_EN adds per-output grant counters. |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module switch_allocator #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    switch_allocator_if.slave      sa
`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
    ,
    output logic [PORT_NUM-1:0][15:0] grant_cnt_o
`endif
);
    localparam int c_PORT_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int c_VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_NUM-1:0][c_VC_W-1:0]   in_ptr_q,  in_ptr_d;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] out_ptr_q, out_ptr_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
    logic [PORT_NUM-1:0]               w_err;
    logic [PORT_NUM-1:0]               w_s1_valid;
    logic [PORT_NUM-1:0][c_VC_W-1:0]   w_s1_vc;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] w_s1_port;
    logic [PORT_NUM-1:0]               w_xb_valid;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] w_xb_sel;
    logic [PORT_NUM-1:0]               w_in_grant;

    // Illegal out_port never reaches the on/off lookup, so no out-of-range index
    always_comb begin : p_elig
        w_elig = '0;
        w_err  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (sa.switch_request_i[p][v]) begin
                    if (32'(sa.out_port_i[p][v]) < PORT_NUM) begin
                        w_elig[p][v] = sa.on_off_i[sa.out_port_i[p][v]][sa.downstream_vc_i[p][v]];
                    end else begin
                        w_err[p] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : p_stage1
        w_s1_valid = '0;
        w_s1_vc    = '0;
        w_s1_port  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                int idx;
                idx = (int'(in_ptr_q[p]) + k) % VC_NUM;
                if (!w_s1_valid[p] && w_elig[p][c_VC_W'(idx)]) begin
                    w_s1_valid[p] = 1'b1;
                    w_s1_vc[p]    = c_VC_W'(idx);
                end
            end
            w_s1_port[p] = sa.out_port_i[p][w_s1_vc[p]];
        end
    end

    // Each input targets a single output, so one grant per input follows for free
    always_comb begin : p_stage2
        w_xb_valid = '0;
        w_xb_sel   = '0;
        w_in_grant = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                int idx;
                idx = (int'(out_ptr_q[o]) + k) % PORT_NUM;
                if (!w_xb_valid[o] && w_s1_valid[c_PORT_W'(idx)] &&
                    (w_s1_port[c_PORT_W'(idx)] == c_PORT_W'(o))) begin
                    w_xb_valid[o] = 1'b1;
                    w_xb_sel[o]   = c_PORT_W'(idx);
                end
            end
            if (w_xb_valid[o]) begin
                w_in_grant[w_xb_sel[o]] = 1'b1;
            end
        end
    end

    always_comb begin : p_outputs
        sa.valid_sel_o = rst ? '0 : w_in_grant;
        sa.xb_valid_o  = rst ? '0 : w_xb_valid;
        sa.error_o     = rst ? '0 : w_err;
        sa.vc_sel_o    = '0;
        sa.xb_sel_o    = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (!rst && w_in_grant[p]) sa.vc_sel_o[p] = w_s1_vc[p];
            if (!rst && w_xb_valid[p]) sa.xb_sel_o[p] = w_xb_sel[p];
        end
    end

    // Pointers advance only on a final grant, one past the winner
    always_comb begin : p_ptr_next
        in_ptr_d  = in_ptr_q;
        out_ptr_d = out_ptr_q;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_in_grant[p]) begin
                in_ptr_d[p] = c_VC_W'((int'(w_s1_vc[p]) + 1) % VC_NUM);
            end
            if (w_xb_valid[p]) begin
                out_ptr_d[p] = c_PORT_W'((int'(w_xb_sel[p]) + 1) % PORT_NUM);
            end
        end
    end

    always_ff @(posedge clk) begin : p_ptr_reg
        if (rst) begin
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
        end else begin
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
        end
    end

`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_grant_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (sa.xb_valid_o[o] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign grant_cnt_o[o] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_switch_allocator                                          |
// | Desc    : Directed and random stimulus against a reference allocator.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_switch_allocator;
    localparam int PN = 5;
    localparam int VN = 2;
    localparam int PW = 3;
    localparam int VW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_allocator_if #(.PORT_NUM(PN), .VC_NUM(VN)) sa_bus ();

`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
    logic [PN-1:0][15:0] grant_cnt;
`endif

    switch_allocator #(.PORT_NUM(PN), .VC_NUM(VN)) dut (
        .clk         (clk),
        .rst         (rst),
        .sa          (sa_bus)
`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    int in_ptr[PN];
    int out_ptr[PN];
    int cnt[PN];
    int exp_cont[6] = '{0, 1, 3, 0, 1, 3};

    logic [PN-1:0]          e_vs, e_xv, e_err;
    logic [PN-1:0][VW-1:0]  e_vc;
    logic [PN-1:0][PW-1:0]  e_xs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: eligibility, VC choice per input, input choice per output
    task automatic model_eval();
        int win[PN];
        int tgt[PN];
        int req[PN][VN];
        int op[PN][VN];
        int dv[PN][VN];
        int onoff[PN][VN];
        for (int p = 0; p < PN; p++) begin
            for (int v = 0; v < VN; v++) begin
                req[p][v]   = int'(sa_bus.switch_request_i[p][v]);
                op[p][v]    = int'(sa_bus.out_port_i[p][v]);
                dv[p][v]    = int'(sa_bus.downstream_vc_i[p][v]);
                onoff[p][v] = int'(sa_bus.on_off_i[p][v]);
            end
        end
        e_vs = '0; e_xv = '0; e_err = '0; e_vc = '0; e_xs = '0;
        for (int p = 0; p < PN; p++) begin
            win[p] = -1;
            tgt[p] = -1;
            for (int v = 0; v < VN; v++) begin
                if (req[p][v] == 1 && op[p][v] >= PN) e_err[p] = 1'b1;
            end
            for (int k = 0; k < VN; k++) begin
                int v;
                v = (in_ptr[p] + k) % VN;
                if (win[p] < 0 && req[p][v] == 1 && op[p][v] < PN &&
                    onoff[op[p][v]][dv[p][v]] == 1) begin
                    win[p] = v;
                    tgt[p] = op[p][v];
                end
            end
        end
        for (int o = 0; o < PN; o++) begin
            for (int k = 0; k < PN; k++) begin
                int p;
                p = (out_ptr[o] + k) % PN;
                if (!e_xv[o] && win[p] >= 0 && tgt[p] == o) begin
                    e_xv[o] = 1'b1;
                    e_xs[o] = PW'(p);
                    e_vs[p] = 1'b1;
                    e_vc[p] = VW'(win[p]);
                end
            end
        end
        if (rst) begin
            e_vs = '0; e_xv = '0; e_err = '0; e_vc = '0; e_xs = '0;
        end
    endtask

    task automatic model_clock();
        for (int o = 0; o < PN; o++) begin
            if (rst) begin
                in_ptr[o] = 0; out_ptr[o] = 0; cnt[o] = 0;
            end else if (e_xv[o]) begin
                int p;
                p = int'(e_xs[o]);
                out_ptr[o] = (p + 1) % PN;
                in_ptr[p]  = (int'(e_vc[p]) + 1) % VN;
                if (cnt[o] < 65535) cnt[o] = cnt[o] + 1;
            end
        end
    endtask

    task automatic eval_check();
        @(negedge clk);
        model_eval();
        chk("valid_sel", 32'(sa_bus.valid_sel_o), 32'(e_vs));
        chk("vc_sel",    32'(sa_bus.vc_sel_o),    32'(e_vc));
        chk("xb_valid",  32'(sa_bus.xb_valid_o),  32'(e_xv));
        chk("xb_sel",    32'(sa_bus.xb_sel_o),    32'(e_xs));
        chk("error",     32'(sa_bus.error_o),     32'(e_err));
`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
        for (int o = 0; o < PN; o++) chk("grant_cnt", 32'(grant_cnt[o]), 32'(cnt[o]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_in();
        sa_bus.switch_request_i = '0;
        sa_bus.out_port_i       = '0;
        sa_bus.downstream_vc_i  = '0;
        sa_bus.on_off_i         = '1;
    endtask

    initial begin
        for (int i = 0; i < PN; i++) begin
            in_ptr[i] = 0; out_ptr[i] = 0; cnt[i] = 0;
        end
        // Reset with every request asserted
        rst = 1'b1;
        clear_in();
        sa_bus.switch_request_i = '1;
        repeat (2) begin
            eval_check();
            chk("rst_valid_sel", 32'(sa_bus.valid_sel_o), 32'h0);
            chk("rst_xb_valid",  32'(sa_bus.xb_valid_o),  32'h0);
            tick();
        end
        rst = 1'b0;
        clear_in();
        sa_bus.switch_request_i[0][0] = 1'b1;
        sa_bus.out_port_i[0][0]       = 3'd2;
        eval_check();
        chk("rel_valid0",  32'(sa_bus.valid_sel_o[0]), 32'd1);
        chk("rel_vc0",     32'(sa_bus.vc_sel_o[0]),    32'd0);
        chk("rel_xvalid2", 32'(sa_bus.xb_valid_o[2]),  32'd1);
        chk("rel_xsel2",   32'(sa_bus.xb_sel_o[2]),    32'd0);
        tick();

        // Output contention on output 4
        clear_in();
        sa_bus.switch_request_i[0][0] = 1'b1; sa_bus.out_port_i[0][0] = 3'd4;
        sa_bus.switch_request_i[1][0] = 1'b1; sa_bus.out_port_i[1][0] = 3'd4;
        sa_bus.switch_request_i[3][0] = 1'b1; sa_bus.out_port_i[3][0] = 3'd4;
        for (int i = 0; i < 6; i++) begin
            eval_check();
            chk("cont_xsel4", 32'(sa_bus.xb_sel_o[4]), 32'(exp_cont[i]));
            chk("cont_pop",   32'($countones(sa_bus.xb_valid_o)), 32'd1);
            tick();
        end

        // VC rotation at input 2
        clear_in();
        sa_bus.switch_request_i[2] = 2'b11;
        sa_bus.out_port_i[2][0] = 3'd1; sa_bus.out_port_i[2][1] = 3'd1;
        sa_bus.downstream_vc_i[2][1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval_check();
            chk("rot_vc2", 32'(sa_bus.vc_sel_o[2]), 32'(i % 2));
            tick();
        end

        // Flow control off then on
        clear_in();
        sa_bus.on_off_i[3][1] = 1'b0;
        sa_bus.switch_request_i[0][1] = 1'b1;
        sa_bus.out_port_i[0][1]       = 3'd3;
        sa_bus.downstream_vc_i[0][1]  = 1'b1;
        eval_check();
        chk("fc_off_valid", 32'(sa_bus.valid_sel_o), 32'h0);
        tick();
        sa_bus.on_off_i[3][1] = 1'b1;
        eval_check();
        chk("fc_on_valid0", 32'(sa_bus.valid_sel_o[0]), 32'd1);
        chk("fc_on_vc0",    32'(sa_bus.vc_sel_o[0]),    32'd1);
        chk("fc_on_xv3",    32'(sa_bus.xb_valid_o[3]),  32'd1);
        tick();

        // Illegal output port
        clear_in();
        sa_bus.switch_request_i[4][0] = 1'b1;
        sa_bus.out_port_i[4][0]       = 3'd6;
        eval_check();
        chk("ill_err4",   32'(sa_bus.error_o[4]),     32'd1);
        chk("ill_valid4", 32'(sa_bus.valid_sel_o[4]), 32'd0);
        chk("ill_xv",     32'(sa_bus.xb_valid_o),     32'h0);
        tick();

        // Mid-operation reset, then full permutation
        rst = 1'b1;
        eval_check();
        tick();
        rst = 1'b0;
        clear_in();
        for (int p = 0; p < PN; p++) begin
            sa_bus.switch_request_i[p][0] = 1'b1;
            sa_bus.out_port_i[p][0]       = PW'((p + 1) % PN);
        end
        repeat (3) begin
            eval_check();
            chk("perm_valid", 32'(sa_bus.valid_sel_o), 32'h1F);
            chk("perm_xv",    32'(sa_bus.xb_valid_o),  32'h1F);
            tick();
        end
`ifdef SWITCH_ALLOCATOR_PERF_CNT_EN
        @(negedge clk);
        for (int o = 0; o < PN; o++) chk("perm_cnt", 32'(grant_cnt[o]), 32'd3);
`endif

        // Random traffic with occasional reset
        repeat (400) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < PN; p++) begin
                for (int v = 0; v < VN; v++) begin
                    sa_bus.switch_request_i[p][v] = 1'($urandom_range(0, 1));
                    sa_bus.out_port_i[p][v]       = PW'($urandom_range(0, 6));
                    sa_bus.downstream_vc_i[p][v]  = VW'($urandom_range(0, 1));
                end
            end
            sa_bus.on_off_i = (PN*VN)'($urandom | $urandom);
            eval_check();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
